// File: rtl/morse_pkg.sv
// Shared types, constants and the digit-to-element mapping for the Morse digit scheduler.
package morse_pkg;

    localparam int unsigned DIGIT_W         = 4;
    localparam int unsigned ELEM_W          = 3;
    localparam int unsigned ELEMS_PER_DIGIT = 5;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
    localparam logic [ELEM_W-1:0]  LAST_ELEM = ELEM_W'(ELEMS_PER_DIGIT - 1);

    typedef enum logic [1:0] {
        OP_DOT       = 2'd0,
        OP_DASH      = 2'd1,
        OP_GAP       = 2'd2,
        OP_DIGIT_GAP = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_MGAP = 2'd2,
        ST_DGAP = 2'd3
    } sched_state_e;

    typedef struct packed {
        cmd_op_e             op;
        logic [DIGIT_W-1:0]  digit;
    } cmd_t;

    // Digits 0..5 start with d dots; digits 6..9 start with d-5 dashes.
    function automatic logic is_dash(input logic [DIGIT_W-1:0] digit,
                                     input logic [ELEM_W-1:0]  idx);
        logic [DIGIT_W-1:0] idx_w;
        idx_w = DIGIT_W'(idx);
        if (digit <= 4'd5) begin
            return idx_w >= digit;
        end
        return idx_w < (digit - 4'd5);
    endfunction

endpackage

// File: rtl/morse_digit_fifo.sv
// DEPTH-entry synchronous digit FIFO with occupancy count and single-cycle flush.
module morse_digit_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data_c,
    output logic [CNT_W-1:0]  count,
    output logic              empty_c,
    output logic              full_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CNT_W'(DEPTH));
    assign do_wr     = wr_en && !full_c && !flush;
    assign do_rd     = rd_en && !empty_c && !flush;
    assign rd_data_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/morse_tx_scheduler.sv
// Round-robin digit intake, FIFO buffering and DOT/DASH/GAP/DIGIT_GAP sequencing.
// Define MORSE_BATCH_EN for number mode: sequencing waits for a go pulse per batch.
module morse_tx_scheduler
    import morse_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_valid,
    input  logic [DIGIT_W-1:0] a_digit,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [DIGIT_W-1:0] b_digit,
    output logic               b_ready,
    input  logic               flush,
    input  logic               go,
    output logic               cmd_valid,
    output logic [1:0]         cmd_op,
    output logic [DIGIT_W-1:0] cmd_digit,
    input  logic               cmd_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               err_digit
);

    sched_state_e       state_q, state_d;
    logic [ELEM_W-1:0]  elem_q, elem_d;
    cmd_t               cmd_q, cmd_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               busy_q, busy_d;
    logic               abort_q, abort_d;
    logic               start_ok;
    logic               accept;
    logic               stop;
    logic               pop;

    logic               rdy_en_q;
    logic               prio_b_q;
    logic               err_q;
    logic               can_wr;
    logic               grant_a;
    logic               grant_b;
    logic               wr_en;
    logic [DIGIT_W-1:0] wr_digit;

    logic [DIGIT_W-1:0] fifo_rd_c;
    logic               fifo_empty_c;
    logic               fifo_full_c;

`ifdef MORSE_BATCH_EN
    logic armed_q, armed_d;
`else
    logic go_unused;
    assign go_unused = go;
`endif

    // Intake arbitration; no grant while full, flushing or still in reset.
    assign can_wr   = rdy_en_q && !flush && !fifo_full_c;
    assign grant_a  = can_wr && a_valid && (!b_valid || !prio_b_q);
    assign grant_b  = can_wr && b_valid && !grant_a;
    assign wr_digit = grant_a ? a_digit : b_digit;
    assign wr_en    = (grant_a || grant_b) && (wr_digit <= MAX_DIGIT);
    assign a_ready  = grant_a;
    assign b_ready  = grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
            prio_b_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            err_q    <= (grant_a || grant_b) && (wr_digit > MAX_DIGIT);
            if (grant_a) begin
                prio_b_q <= 1'b1;
            end else if (grant_b) begin
                prio_b_q <= 1'b0;
            end
        end
    end

    morse_digit_fifo #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .DATA_W (DIGIT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_digit),
        .rd_en     (pop),
        .rd_data_c (fifo_rd_c),
        .count     (fifo_count),
        .empty_c   (fifo_empty_c),
        .full_c    (fifo_full_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            cmd_q       <= '{op: OP_DOT, digit: '0};
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
`ifdef MORSE_BATCH_EN
            armed_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            abort_q     <= abort_d;
`ifdef MORSE_BATCH_EN
            armed_q     <= armed_d;
`endif
        end
    end

    // Next state plus next registered command; a pending command always completes before abort.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        cmd_d   = cmd_q;
        abort_d = abort_q;
        pop     = 1'b0;
        accept  = cmd_valid_q && cmd_ready;
        stop    = abort_q || flush;
`ifdef MORSE_BATCH_EN
        armed_d  = armed_q;
        start_ok = armed_q;
        if ((state_q == ST_IDLE) && go) armed_d = 1'b1;
`else
        start_ok = 1'b1;
`endif
        if ((state_q != ST_IDLE) && flush) abort_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_ok && !fifo_empty_c && !flush) begin
                    pop         = 1'b1;
                    cmd_d.digit = fifo_rd_c;
                    elem_d      = '0;
                    state_d     = ST_MARK;
                end
            end
            ST_MARK: begin
                if (accept) state_d = stop ? ST_IDLE : ST_MGAP;
            end
            ST_MGAP: begin
                if (accept) begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (elem_q != LAST_ELEM) begin
                        elem_d  = elem_q + ELEM_W'(1);
                        state_d = ST_MARK;
                    end else if (!fifo_empty_c) begin
                        state_d = ST_DGAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DGAP: begin
                if (accept) begin
                    if (stop || fifo_empty_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        pop         = 1'b1;
                        cmd_d.digit = fifo_rd_c;
                        elem_d      = '0;
                        state_d     = ST_MARK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            abort_d = 1'b0;
`ifdef MORSE_BATCH_EN
            if (state_q != ST_IDLE) armed_d = 1'b0;
`endif
        end

        case (state_d)
            ST_MARK: cmd_d.op = is_dash(cmd_d.digit, elem_d) ? OP_DASH : OP_DOT;
            ST_MGAP: cmd_d.op = OP_GAP;
            ST_DGAP: cmd_d.op = OP_DIGIT_GAP;
            default: cmd_d.op = OP_DOT;
        endcase
        cmd_valid_d = (state_d != ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_q.op;
    assign cmd_digit = cmd_q.digit;
    assign busy      = busy_q;
    assign err_digit = err_q;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Scoreboard bench for morse_tx_scheduler: expected commands are queued at digit handshake
// and a monitor pops/compares on every accepted command. Honours MORSE_BATCH_EN.
`timescale 1ns/1ps
module tb_morse_tx_scheduler;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_valid = 1'b0;
    logic [3:0]       a_digit = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [3:0]       b_digit = '0;
    logic             b_ready;
    logic             flush = 1'b0;
    logic             go = 1'b0;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [3:0]       cmd_digit;
    logic             cmd_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;
    logic             err_digit;

    always #5 clk = ~clk;

    morse_tx_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_digit    (a_digit),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_digit    (b_digit),
        .b_ready    (b_ready),
        .flush      (flush),
        .go         (go),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_digit  (cmd_digit),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .fifo_count (fifo_count),
        .err_digit  (err_digit)
    );

    typedef struct {
        int op;
        int digit;
    } exp_t;

    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    err_seen = 0;
    int    err_exp = 0;
    int    rdy_mode = 0;
    bit    run_open = 1'b0;
    int    prev_digit = 0;
    bit    exp_prio_b = 1'b0;
    string morse_tab[10] = '{"-----", ".----", "..---", "...--", "....-",
                             ".....", "-....", "--...", "---..", "----."};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference: each digit is five mark/GAP pairs; consecutive digits of one run are split by DIGIT_GAP.
    task automatic push_digit(input int d);
        exp_t e;
        byte  c;
        if (run_open) begin
            e.op = 3;
            e.digit = prev_digit;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            c = morse_tab[d][i];
            e.digit = d;
            e.op = (c == "-") ? 1 : 0;
            exp_q.push_back(e);
            e.op = 2;
            exp_q.push_back(e);
        end
        prev_digit = d;
        run_open = 1'b1;
    endtask

    task automatic write_digit(input bit use_b, input int d);
        bit done = 1'b0;
        if (use_b) begin
            b_valid = 1'b1;
            b_digit = 4'(d);
        end else begin
            a_valid = 1'b1;
            a_digit = 4'(d);
        end
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (use_b ? b_ready : a_ready) done = 1'b1;
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("write_accepted", 32'(done), 1);
        if (done) begin
            exp_prio_b = !use_b;
            if (d <= 9) push_digit(d);
            else err_exp++;
        end
    endtask

    task automatic kick();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (!busy && !cmd_valid && exp_q.size() == 0 && fifo_count == 0) ok = 1'b1;
        end
        check({name, "_drained"}, 32'(ok), 1);
        check({name, "_err_pulses"}, 32'(err_seen), 32'(err_exp));
        run_open = 1'b0;
        step();
    endtask

    // cmd_ready driver: 0 = hold low, 1 = hold high, otherwise random per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       cmd_ready = 1'b0;
                1:       cmd_ready = 1'b1;
                default: cmd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop on accept, stability and no-drop while stalled.
    logic [1:0] last_op;
    logic [3:0] last_digit;
    bit         last_pending = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (err_digit) err_seen++;
        if (!rst_n) begin
            last_pending = 1'b0;
        end else if (cmd_valid) begin
            if (last_pending) begin
                check("op_stable", 32'(cmd_op), 32'(last_op));
                check("digit_stable", 32'(cmd_digit), 32'(last_digit));
            end
            if (cmd_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd: got op %0d digit %0d, expected no command",
                             cmd_op, cmd_digit);
                end else begin
                    e = exp_q.pop_front();
                    if (cmd_op !== 2'(e.op) || cmd_digit !== 4'(e.digit)) begin
                        errors++;
                        $display("FAIL cmd: got op %0d digit %0d, expected op %0d digit %0d",
                                 cmd_op, cmd_digit, e.op, e.digit);
                    end
                end
                last_pending = 1'b0;
            end else begin
                last_pending = 1'b1;
                last_op = cmd_op;
                last_digit = cmd_digit;
            end
        end else begin
            if (last_pending) begin
                checks++;
                errors++;
                $display("FAIL valid_dropped: got cmd_valid 0, expected 1 until accept");
            end
            last_pending = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        int  d;
        int  da;
        int  db;
        int  wrote;
        bit  granted;
        bit  seen;

        // Reset values with both requesters asserting.
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_cmd_op", 32'(cmd_op), 0);
        check("rst_cmd_digit", 32'(cmd_digit), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_err_digit", 32'(err_digit), 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        step();

        // Round-robin from reset: both valid for four cycles.
        rdy_mode = 1;
        exp_prio_b = 1'b0;
        a_valid = 1'b1; a_digit = 4'd1;
        b_valid = 1'b1; b_digit = 4'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_a_ready", 32'(a_ready), 32'(!exp_prio_b));
            check("rr_b_ready", 32'(b_ready), 32'(exp_prio_b));
            push_digit(exp_prio_b ? 2 : 1);
            exp_prio_b = !exp_prio_b;
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        kick();
        wait_idle("rr");

        // Single digit 3 from A, plus first-command latency.
        rdy_mode = 1;
        write_digit(1'b0, 3);
`ifndef MORSE_BATCH_EN
        @(negedge clk);
        check("lat_n1_valid", 32'(cmd_valid), 0);
        @(negedge clk);
        check("lat_n2_valid", 32'(cmd_valid), 1);
        check("lat_n2_digit", 32'(cmd_digit), 3);
`endif
        kick();
        wait_idle("digit3");

        // Invalid digit: handshake, one err pulse, nothing queued.
        rdy_mode = 1;
        write_digit(1'b0, 12);
        @(negedge clk);
        check("err_pulse", 32'(err_digit), 1);
        check("err_count", 32'(fifo_count), 0);
        @(negedge clk);
        check("err_pulse_end", 32'(err_digit), 0);
        repeat (20) step();
        wait_idle("err");

        // Fill to DEPTH with the engine stalled; the next digit needs a pop.
        rdy_mode = 0;
        wrote = 0;
        while (fifo_count != CNT_W'(DEPTH) && wrote < DEPTH + 2) begin
            write_digit(1'(wrote % 2), int'($urandom_range(0, 9)));
            wrote++;
        end
        check("fill_count", 32'(fifo_count), DEPTH);
`ifdef MORSE_BATCH_EN
        check("fill_writes", 32'(wrote), DEPTH);
`else
        check("fill_writes", 32'(wrote), DEPTH + 1);
`endif
        da = int'($urandom_range(0, 9));
        db = int'($urandom_range(0, 9));
        a_valid = 1'b1; a_digit = 4'(da);
        b_valid = 1'b1; b_digit = 4'(db);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("full_a_ready", 32'(a_ready), 0);
            check("full_b_ready", 32'(b_ready), 0);
            step();
        end
        kick();
        rdy_mode = 1;
        granted = 1'b0;
        for (int t = 0; t < 100 && !granted; t++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin
                granted = 1'b1;
                check("refill_count", 32'(fifo_count), DEPTH - 1);
                check("refill_a_ready", 32'(a_ready), 32'(!exp_prio_b));
                check("refill_b_ready", 32'(b_ready), 32'(exp_prio_b));
                push_digit(exp_prio_b ? db : da);
                exp_prio_b = !exp_prio_b;
            end
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("refill_granted", 32'(granted), 1);
        wait_idle("fill");

        // Long stall in MARK, then flush: current command completes, queue discarded.
        rdy_mode = 0;
        write_digit(1'b0, 6);
        write_digit(1'b1, 2);
        write_digit(1'b0, 8);
        kick();
        repeat (20) step();
        @(negedge clk);
        check("stall_valid", 32'(cmd_valid), 1);
        check("stall_op", 32'(cmd_op), 1);
        check("stall_digit", 32'(cmd_digit), 6);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        run_open = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        check("flush_count", 32'(fifo_count), 0);
        check("flush_still_valid", 32'(cmd_valid), 1);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (cmd_valid && cmd_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check("flush_accept", 32'(seen), 1);
        @(negedge clk);
        check("flush_valid_low", 32'(cmd_valid), 0);
        check("flush_busy_low", 32'(busy), 0);
        check("flush_count_end", 32'(fifo_count), 0);
        check("flush_sb_empty", 32'(exp_q.size()), 0);
        wait_idle("flush");

`ifdef MORSE_BATCH_EN
        // Number mode: nothing moves until go.
        rdy_mode = 1;
        write_digit(1'b0, 4);
        write_digit(1'b1, 7);
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1'b1;
        end
        check("batch_no_go_valid", 32'(seen), 0);
        check("batch_queued", 32'(fifo_count), 2);
        kick();
        wait_idle("batch");
`endif

        // Randomised bursts: queue with the engine stalled, then drain with random ready.
        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(1, 6));
            rdy_mode = 0;
            for (int k = 0; k < n; k++) begin
                d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                                : int'($urandom_range(0, 9));
                write_digit(1'($urandom_range(0, 1)), d);
                if ($urandom_range(0, 1) == 1) step();
            end
            kick();
            rdy_mode = 2;
            wait_idle("burst");
        end

        // Reset mid-sequence returns everything to reset values.
        rdy_mode = 0;
        write_digit(1'b0, 8);
        write_digit(1'b1, 9);
        kick();
        rdy_mode = 2;
        repeat (8) step();
        rst_n = 1'b0;
        a_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(cmd_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_op", 32'(cmd_op), 0);
        check("mid_rst_digit", 32'(cmd_digit), 0);
        check("mid_rst_a_ready", 32'(a_ready), 0);
        exp_q.delete();
        run_open = 1'b0;
        a_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        rdy_mode = 1;
        repeat (10) step();
        check("post_rst_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
